// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types and constants for the idli memory arbiter
package idli_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } mem_state_t;

  typedef enum logic {
    FETCH,
    LS
  } mem_req_t;

  localparam logic [7:0] MEM_CMD_RD = 8'h03;
  localparam logic [7:0] MEM_CMD_WR = 8'h02;

endpackage

// File: rtl/idli_mem_arb_m.sv
// rtl/idli_mem_arb_m.sv - SQI SRAM port arbiter for instruction fetch and load/store
module idli_mem_arb_m
  import idli_pkg::*;
#(
  parameter logic [7:0] P_CMD_RD = MEM_CMD_RD,
  parameter logic [7:0] P_CMD_WR = MEM_CMD_WR
) (
  input  logic        i_mem_gck,
  input  logic        i_mem_rst_n,
  input  logic [1:0]  i_mem_ctr,
  input  logic        i_mem_ctr_last_cycle,
  input  logic        i_mem_fetch_req,
  input  logic [15:0] i_mem_fetch_addr,
  output logic        o_mem_fetch_ack,
  input  logic        i_mem_ls_req,
  input  logic        i_mem_ls_wr,
  input  logic [15:0] i_mem_ls_addr,
  input  logic [15:0] i_mem_ls_wdata,
  output logic        o_mem_ls_ack,
  output logic [15:0] o_mem_rd_data,
  output logic        o_mem_cs_n,
  output logic        o_mem_sio_oe,
  output logic [3:0]  o_mem_sio,
  input  logic [3:0]  i_mem_sio
);

  mem_state_t  state, state_d;
  mem_req_t    last_grant, last_d;
  logic        wr, wr_d, pick_ls, done;
  logic [15:0] addr, addr_d, wdata, wdata_d, rd_word;
  logic [11:0] shift;
  logic [1:0]  ctr_d;
  logic [7:0]  cmd;
  logic        cs_d, oe_d;
  logic [3:0]  sio_d;

  always_comb begin
    state_d = state;
    last_d  = last_grant;
    wr_d    = wr;
    addr_d  = addr;
    wdata_d = wdata;
    pick_ls = 1'b0;
    if (i_mem_ctr_last_cycle) begin
      case (state)
        IDLE: if (i_mem_fetch_req || i_mem_ls_req) begin
          // Round-robin on a tie: favour whoever did not win last time.
          pick_ls = i_mem_ls_req && (!i_mem_fetch_req || last_grant == FETCH);
          last_d  = pick_ls ? LS : FETCH;
          wr_d    = pick_ls && i_mem_ls_wr;
          addr_d  = pick_ls ? i_mem_ls_addr : i_mem_fetch_addr;
          wdata_d = i_mem_ls_wdata;
          state_d = CMD;
        end
        CMD:     state_d = ADDR;
        ADDR:    state_d = DATA;
        DATA:    state_d = GAP;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pad outputs are registered, so they are computed for the next cycle's state and counter.
  always_comb begin
    ctr_d = i_mem_ctr + 2'd1;
    cmd   = wr_d ? P_CMD_WR : P_CMD_RD;
    cs_d  = 1'b1;
    oe_d  = 1'b0;
    sio_d = 4'h0;
    case (state_d)
      CMD: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
        case (ctr_d)
          2'd0:    sio_d = cmd[7:4];
          2'd1:    sio_d = cmd[3:0];
          2'd2:    sio_d = addr_d[15:12];
          default: sio_d = addr_d[11:8];
        endcase
      end
      ADDR: begin
        cs_d = 1'b0;
        oe_d = !ctr_d[1] || wr_d;
        case (ctr_d)
          2'd0:    sio_d = addr_d[7:4];
          2'd1:    sio_d = addr_d[3:0];
          2'd2:    sio_d = wr_d ? wdata_d[15:12] : 4'h0;
          default: sio_d = wr_d ? wdata_d[11:8] : 4'h0;
        endcase
      end
      DATA: begin
        if (!wr_d) begin
          cs_d = 1'b0;
        end else if (!ctr_d[1]) begin
          cs_d  = 1'b0;
          oe_d  = 1'b1;
          sio_d = ctr_d[0] ? wdata_d[3:0] : wdata_d[7:4];
        end
      end
      default: ;
    endcase
  end

  assign rd_word = {shift, i_mem_sio};
  assign done    = (state == DATA) && i_mem_ctr_last_cycle;

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state           <= IDLE;
      last_grant      <= FETCH;
      wr              <= 1'b0;
      addr            <= 16'h0;
      wdata           <= 16'h0;
      shift           <= 12'h0;
      o_mem_cs_n      <= 1'b1;
      o_mem_sio_oe    <= 1'b0;
      o_mem_sio       <= 4'h0;
      o_mem_fetch_ack <= 1'b0;
      o_mem_ls_ack    <= 1'b0;
      o_mem_rd_data   <= 16'h0;
    end else begin
      state           <= state_d;
      last_grant      <= last_d;
      wr              <= wr_d;
      addr            <= addr_d;
      wdata           <= wdata_d;
      o_mem_cs_n      <= cs_d;
      o_mem_sio_oe    <= oe_d;
      o_mem_sio       <= sio_d;
      o_mem_fetch_ack <= done && last_grant == FETCH;
      o_mem_ls_ack    <= done && last_grant == LS;
      if (state == DATA) shift <= rd_word[11:0];
      if (done && !wr) o_mem_rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// tb/tb_idli_mem_arb_m.sv - self-checking bench for idli_mem_arb_m with an SQI SRAM model
module tb_idli_mem_arb_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ctr = 2'd0;
  logic        last;
  logic        fetch_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
  logic [15:0] fetch_addr = 16'h0, ls_addr = 16'h0, ls_wdata = 16'h0;
  logic        fetch_ack, ls_ack, cs_n, sio_oe;
  logic [15:0] rd_data;
  logic [3:0]  sio;
  logic [3:0]  sio_in = 4'h0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [39:0] seq;
    int          len;
    bit          ok;
  } txn_t;

  txn_t        txq[$];
  logic [15:0] mem[logic [15:0]];
  logic [15:0] shadow[logic [15:0]];
  int          errors = 0, checks = 0, viol = 0;
  logic        prev_cs = 1'b1;

  idli_mem_arb_m dut (
    .i_mem_gck(clk), .i_mem_rst_n(rst_n), .i_mem_ctr(ctr), .i_mem_ctr_last_cycle(last),
    .i_mem_fetch_req(fetch_req), .i_mem_fetch_addr(fetch_addr), .o_mem_fetch_ack(fetch_ack),
    .i_mem_ls_req(ls_req), .i_mem_ls_wr(ls_wr), .i_mem_ls_addr(ls_addr),
    .i_mem_ls_wdata(ls_wdata), .o_mem_ls_ack(ls_ack), .o_mem_rd_data(rd_data),
    .o_mem_cs_n(cs_n), .o_mem_sio_oe(sio_oe), .o_mem_sio(sio), .i_mem_sio(sio_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ctr <= ctr + 2'd1;
  assign last = (ctr == 2'd3);

  // Cycle-level protocol watch: exclusive acks, chip select only falls at a beat start.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_ack && ls_ack) viol <= viol + 1;
      if (prev_cs && !cs_n && ctr != 2'd0) viol <= viol + 1;
    end
    prev_cs <= cs_n;
  end

  // SQI SRAM: decodes the pin sequence, serves read data, records each transaction.
  initial begin : sram
    int n;
    logic wr, exp_oe;
    logic [7:0] cmd;
    logic [15:0] a, d;
    logic [39:0] seq;
    bit ok;
    txn_t t;
    mem[16'h1234] = 16'hABCD;
    n = 0; wr = 0; cmd = 0; a = 0; d = 0; seq = 0; ok = 1;
    forever begin
      @(negedge clk);
      sio_in = 4'($urandom);
      if (!rst_n) begin
        n = 0;
      end else if (cs_n) begin
        if (n > 0) begin
          if (wr) mem[a] = d;
          t.cmd = cmd; t.addr = a; t.data = d; t.seq = seq; t.len = n; t.ok = ok;
          txq.push_back(t);
          n = 0;
        end
      end else begin
        if (n == 0) begin seq = 0; ok = 1; cmd = 0; a = 0; d = 0; wr = 0; end
        exp_oe = (n < 6) || (wr && n < 10);
        if (sio_oe !== exp_oe || (!sio_oe && sio !== 4'h0)) ok = 0;
        if (n < 10) seq = {seq[35:0], sio};
        if (n < 2) cmd = {cmd[3:0], sio};
        else if (n < 6) a = {a[11:0], sio};
        else if (wr && n < 10) d = {d[11:0], sio};
        if (n == 1) wr = (cmd == 8'h02);
        if (!wr && n == 5) d = mem.exists(a) ? mem[a] : (a ^ 16'h5A5A);
        if (!wr && n >= 8 && n < 12) sio_in = d[(11 - n) * 4 +: 4];
        n++;
      end
    end
  end

  function automatic logic [15:0] pred(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input bit want_ls, output int lat);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (fetch_ack || ls_ack) break;
    end
    chk("ack_seen", fetch_ack || ls_ack, 1);
    chk("ack_sel", {fetch_ack, ls_ack}, want_ls ? 2'b01 : 2'b10);
  endtask

  task automatic wait_ctr(input logic [1:0] p);
    for (int k = 0; k < 8; k++) begin
      if (ctr == p) break;
      @(negedge clk);
    end
  endtask

  task automatic check_txn(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] d,
                           input int len, input bit use_seq, input logic [39:0] seq);
    txn_t t;
    @(negedge clk);
    chk("txn_cnt", txq.size(), 1);
    if (txq.size() > 0) begin
      t = txq.pop_front();
      chk("txn_cmd", t.cmd, cmd);
      chk("txn_addr", t.addr, a);
      chk("txn_data", t.data, d);
      chk("txn_len", t.len, len);
      chk("txn_proto", t.ok, 1);
      if (use_seq) chk("txn_seq", t.seq, seq);
    end
    txq.delete();
  endtask

  initial begin
    int lat, hi, acks, lows, kind, p;
    bit model_last_ls, win_ls, w, wr_exp;
    logic [15:0] exp_rd, fa, la, wd, a_exp;

    shadow[16'h1234] = 16'hABCD;
    model_last_ls = 0;
    exp_rd = 16'h0;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_oe", sio_oe, 0);
    chk("rst_sio", sio, 0);
    chk("rst_acks", {fetch_ack, ls_ack}, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed fetch of 0x1234.
    wait_ctr(2'd0);
    fetch_addr = 16'h1234; fetch_req = 1'b1;
    wait_ack(1'b0, lat);
    fetch_req = 1'b0;
    exp_rd = 16'hABCD;
    chk("fetch_lat", lat, 16);
    chk("fetch_rd", rd_data, exp_rd);
    check_txn(8'h03, 16'h1234, 16'hABCD, 12, 1, 40'h0312340000);
    model_last_ls = 0;

    // Directed store of 0xBEEF to 0x00F0.
    repeat (3) @(negedge clk);
    wait_ctr(2'd0);
    ls_wr = 1'b1; ls_addr = 16'h00F0; ls_wdata = 16'hBEEF; ls_req = 1'b1;
    wait_ack(1'b1, lat);
    ls_req = 1'b0;
    chk("store_lat", lat, 16);
    chk("store_rd_kept", rd_data, exp_rd);
    check_txn(8'h02, 16'h00F0, 16'hBEEF, 10, 1, 40'h0200F0BEEF);
    shadow[16'h00F0] = 16'hBEEF;
    model_last_ls = 1;

    // Fetch raised mid-beat waits for the boundary.
    repeat (3) @(negedge clk);
    wait_ctr(2'd1);
    fetch_addr = 16'h00F0; fetch_req = 1'b1;
    wait_ack(1'b0, lat);
    fetch_req = 1'b0;
    exp_rd = pred(16'h00F0);
    chk("midbeat_lat", lat, 15);
    chk("midbeat_rd", rd_data, exp_rd);
    check_txn(8'h03, 16'h00F0, exp_rd, 12, 0, 0);

    // Request dropped before ack still completes.
    repeat (3) @(negedge clk);
    wait_ctr(2'd0);
    fetch_addr = 16'h0042; fetch_req = 1'b1;
    repeat (6) @(negedge clk);
    fetch_req = 1'b0;
    wait_ack(1'b0, lat);
    exp_rd = pred(16'h0042);
    chk("drop_lat", lat, 10);
    chk("drop_rd", rd_data, exp_rd);
    check_txn(8'h03, 16'h0042, exp_rd, 12, 0, 0);

    // Back-to-back fetches: deselect gap and next-ack spacing.
    repeat (3) @(negedge clk);
    wait_ctr(2'd0);
    fetch_addr = 16'h0100; fetch_req = 1'b1;
    wait_ack(1'b0, lat);
    exp_rd = pred(16'h0100);
    chk("b2b_rd0", rd_data, exp_rd);
    check_txn(8'h03, 16'h0100, exp_rd, 12, 0, 0);
    hi = 2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!cs_n) break;
      hi++;
    end
    chk("b2b_gap", hi, 8);
    wait_ack(1'b0, lat);
    fetch_req = 1'b0;
    chk("b2b_lat", lat, 12);
    chk("b2b_rd1", rd_data, exp_rd);
    check_txn(8'h03, 16'h0100, exp_rd, 12, 0, 0);

    // Reset in the middle of a DATA beat.
    repeat (3) @(negedge clk);
    wait_ctr(2'd0);
    fetch_addr = 16'h0200; fetch_req = 1'b1;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    fetch_req = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_oe", sio_oe, 0);
    acks = 0; lows = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      if (fetch_ack || ls_ack) acks++;
      if (!cs_n) lows++;
    end
    chk("abort_acks", acks, 0);
    chk("abort_cs_low", lows, 0);
    exp_rd = 16'h0;
    chk("abort_rd", rd_data, exp_rd);
    txq.delete();

    // Both requests held from reset: LS, FETCH, LS.
    rst_n = 1'b0;
    fetch_addr = 16'h0300; ls_addr = 16'h0400; ls_wr = 1'b0;
    fetch_req = 1'b1; ls_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b1, lat);
    exp_rd = pred(16'h0400);
    chk("rr0_rd", rd_data, exp_rd);
    check_txn(8'h03, 16'h0400, exp_rd, 12, 0, 0);
    wait_ack(1'b0, lat);
    exp_rd = pred(16'h0300);
    chk("rr1_lat", lat, 19);
    chk("rr1_rd", rd_data, exp_rd);
    check_txn(8'h03, 16'h0300, exp_rd, 12, 0, 0);
    wait_ack(1'b1, lat);
    fetch_req = 1'b0; ls_req = 1'b0;
    exp_rd = pred(16'h0400);
    chk("rr2_lat", lat, 19);
    check_txn(8'h03, 16'h0400, exp_rd, 12, 0, 0);
    model_last_ls = 1;
    repeat (3) @(negedge clk);

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 2);
      fa = 16'($urandom); la = 16'($urandom); wd = 16'($urandom); w = 1'($urandom);
      win_ls = (kind == 1) || (kind == 2 && !model_last_ls);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      p = int'(ctr);
      fetch_addr = fa; ls_addr = la; ls_wdata = wd; ls_wr = w;
      fetch_req = (kind != 1); ls_req = (kind != 0);
      wait_ack(win_ls, lat);
      fetch_req = 1'b0; ls_req = 1'b0;
      model_last_ls = win_ls;
      wr_exp = win_ls && w;
      a_exp = win_ls ? la : fa;
      if (!wr_exp) exp_rd = pred(a_exp);
      chk("rand_lat", lat, 16 - p);
      chk("rand_rd", rd_data, exp_rd);
      check_txn(wr_exp ? 8'h02 : 8'h03, a_exp, wr_exp ? wd : pred(a_exp), wr_exp ? 10 : 12, 0, 0);
      if (wr_exp) shadow[a_exp] = wd;
      repeat (3) @(negedge clk);
    end

    chk("protocol_watch", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
